// File: rtl/mdu_seq_if.sv
// Request/result bundle for the sequential multiply/divide unit.
// Master issues operations and HI/LO writes; slave returns status and results.
interface mdu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, data1, data2, wr_hi, wr_lo, wr_data,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, data1, data2, wr_hi, wr_lo, wr_data,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mdu_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Latency: WIDTH+1 cycles from accepted start to done (2 cycles for divide by zero).
// Backpressure: start is ignored while busy; HI/LO writes are dropped while busy or fixing up.
module mdu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic     clk,
    input  logic     rst_n,
    mdu_seq_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] acc, mq, opnd;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [CNT_W-1:0] cnt;
    logic             is_div, neg_res, neg_rem, dz, div_zero_q;

    logic accept, iter, last, wr_ok, busy_c, done_c;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) state_nxt = bus.op[1] ? S_DIV : S_MUL;
                else        state_nxt = S_IDLE;
            end
            S_MUL:   if (last) state_nxt = S_FIX;
            S_DIV:   if (dz || last) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- output / control decode ----------------
    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        wr_ok  = 1'b0;
        iter   = 1'b0;
        case (state)
            S_IDLE:       wr_ok  = 1'b1;
            S_MUL, S_DIV: begin busy_c = 1'b1; iter = 1'b1; end
            S_FIX:        busy_c = 1'b1;
            S_DONE:       begin done_c = 1'b1; wr_ok = 1'b1; end
            default:      ;
        endcase
        accept = wr_ok && bus.start;
        last   = (cnt == CNT_W'(WIDTH - 1));
    end

    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

    // ---------------- operand conditioning ----------------
    logic             d1_neg, d2_neg, dz_in;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        d1_neg = ~bus.op[0] & bus.data1[WIDTH-1];
        d2_neg = ~bus.op[0] & bus.data2[WIDTH-1];
        a_mag  = d1_neg ? -bus.data1 : bus.data1;
        b_mag  = d2_neg ? -bus.data2 : bus.data2;
        dz_in  = bus.op[1] && (bus.data2 == '0);
    end

    // ---------------- iteration datapath ----------------
    logic [WIDTH:0] msum, dtrial, ddiff;
    logic           q_bit;

    always_comb begin
        msum   = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
        dtrial = {acc, mq[WIDTH-1]};
        ddiff  = dtrial - {1'b0, opnd};
        q_bit  = ~ddiff[WIDTH];
    end

    // mq holds the multiplier (then product low half) or the dividend (then quotient);
    // on divide by zero it keeps the raw dividend so FIX can return it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            mq      <= '0;
            opnd    <= '0;
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
        end else if (accept) begin
            acc     <= '0;
            mq      <= dz_in ? bus.data1 : a_mag;
            opnd    <= b_mag;
            cnt     <= '0;
            is_div  <= bus.op[1];
            neg_res <= d1_neg ^ d2_neg;
            neg_rem <= d1_neg;
            dz      <= dz_in;
        end else if (iter) begin
            cnt <= cnt + CNT_W'(1);
            if (state == S_MUL) begin
                acc <= msum[WIDTH:1];
                mq  <= {msum[0], mq[WIDTH-1:1]};
            end else if (!dz) begin
                acc <= q_bit ? ddiff[WIDTH-1:0] : dtrial[WIDTH-1:0];
                mq  <= {mq[WIDTH-2:0], q_bit};
            end
        end
    end

    // ---------------- sign fix-up and result registers ----------------
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    always_comb begin
        prod_s = neg_res ? -{acc, mq} : {acc, mq};
        if (!is_div) begin
            fix_hi = prod_s[2*WIDTH-1:WIDTH];
            fix_lo = prod_s[WIDTH-1:0];
        end else if (dz) begin
            fix_hi = mq;
            fix_lo = '1;
        end else begin
            fix_hi = neg_rem ? -acc : acc;
            fix_lo = neg_res ? -mq : mq;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else if (state == S_FIX) begin
            hi_q       <= fix_hi;
            lo_q       <= fix_lo;
            div_zero_q <= dz;
        end else if (wr_ok) begin
            if (bus.wr_hi) hi_q <= bus.wr_data;
            if (bus.wr_lo) lo_q <= bus.wr_data;
        end
    end
endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand, HI and LO width; legal values are even and at least 8.
REQ-002 Parameter CNT_W, default 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.
REQ-003 Clock and reset: one clock, reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request a new operation; sampled only while busy=0.
REQ-007 op  input  2  operation select: 00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
REQ-008 data1  input  WIDTH  multiplicand or dividend.
REQ-009 data2  input  WIDTH  multiplier or divisor.
REQ-010 wr_hi, wr_lo  input  1 each  direct register write strobes (MTHI/MTLO).
REQ-011 wr_data  input  WIDTH  data for wr_hi and wr_lo.
REQ-012 busy  output  1  high while an operation is in flight.
REQ-013 done  output  1  one-cycle pulse when hi and lo take a new result.
REQ-014 div_zero  output  1  sticky flag: last completed operation was a divide by zero.
REQ-015 hi, lo  output  WIDTH each  result registers.

Function
REQ-016 FSM states: IDLE, MUL, DIV, FIX, DONE; reset state is IDLE.
REQ-017 In IDLE, start=1 latches op, data1 and data2 at edge k; busy=1 from k; the FSM enters MUL (op[1]=0) or DIV (op[1]=1).
REQ-018 Signed ops convert both operands to magnitudes on latch; result signs are recorded for the FIX state.
REQ-019 MUL: radix-2 shift-add, one bit per cycle, exactly WIDTH cycles, then FIX.
REQ-020 DIV: restoring division, one quotient bit per cycle, exactly WIDTH cycles, then FIX.
REQ-021 FIX state (1 cycle), multiply: applies the sign to the 2*WIDTH product; hi gets the upper half and lo the lower half.
REQ-022 FIX state, divide: quotient to lo, truncated toward zero; remainder to hi, with the sign of the dividend.
REQ-023 FIX writes hi, lo and div_zero and moves to DONE; in DONE, done=1 and busy=0, then the FSM returns to IDLE.
REQ-024 Timing: start at edge k gives new hi/lo and done=1 after edge k+WIDTH+1; busy falls at the same edge.
REQ-025 A new start is accepted in the DONE cycle, which allows back-to-back operations.
REQ-026 Divide by zero (data2=0, op[1]=1): skip the iterations and go straight to FIX at edge k+1.
REQ-027 Divide-by-zero result: hi=data1 unmodified, lo=all ones, div_zero=1; done after edge k+2.
REQ-028 div_zero clears when any later operation completes without a divide by zero.
REQ-029 Signed overflow (most-negative dividend / -1): lo=most-negative value, hi=0, with no flag.
REQ-030 Signed multiply of two most-negative values is exact: hi=0x40000000, lo=0 at WIDTH=32.
REQ-031 start while busy=1 is ignored and does not alter the operation in flight.
REQ-032 wr_hi/wr_lo act only while busy=0 and the FSM is not in FIX; otherwise they are dropped.
REQ-033 Register write and start in the same cycle: the write takes effect and the start is also accepted; the later result overwrites hi/lo.
REQ-034 wr_hi and wr_lo together load wr_data into both registers.
REQ-035 hi and lo hold their value between operations; a completed operation always rewrites both.
REQ-036 All outputs are registered; no combinational path exists from any input to any output.

Reset
REQ-037 rst_n low forces, asynchronously: FSM=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, internal accumulators=0.
REQ-038 Reset during an operation abandons it; no done pulse follows reset release.
REQ-039 The first start is accepted at the first rising edge after rst_n goes high.

Verification
REQ-040 MULT: data1=0xFFFFFFFD, data2=7 at edge k -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, done after edge k+33, busy high for cycles k..k+32.
REQ-041 DIVU 100/7, then DIV 0xFFFFFFF9 / 2 issued in the DONE cycle -> first lo=14, hi=2; then lo=0xFFFFFFFD, hi=0xFFFFFFFF; two done pulses 34 cycles apart.
REQ-042 DIV 0x12345678 / 0 -> hi=0x12345678, lo=0xFFFFFFFF, div_zero=1, done after edge k+2; a following MULTU 3*5 -> lo=15, hi=0, div_zero=0.
REQ-043 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
REQ-044 Start MULTU, pulse start with other operands at cycle k+5, and pulse wr_hi at k+6 -> second start and write ignored; result is from the first operands.
REQ-045 Start DIVU, drive rst_n low at cycle k+10 for 2 cycles -> busy=0, hi=lo=0 immediately; no done for the next 40 cycles; wr_lo=0xA5A5A5A5 while idle -> lo=0xA5A5A5A5.
